ahb_master_req_ctrl: RTL and testbench

Per-master request front-end that sits directly upstream of the per-slave AHB arbiters. It decodes the master's target slave from the address, raises `hreq` and `hlast` toward that slave's arbiter, and counts burst beats so `hlast` marks the final beat. It holds the master (`hready_m` low) until the arbiter grants, and returns an AHB ERROR response for unmapped addresses.

---
 rtl/ahb_master_req_ctrl_if.sv | 48 ++++
 rtl/ahb_master_req_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ahb_master_req_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl_if
//   Bundles the signals between one AHB master, its request front-end
//   (ahb_master_req_ctrl) and the per-slave arbiters.
//
//   Parameters:
//     SLAVE_NUM - number of slave arbiters (width of hreq/hlast/hgrant)
//     ADDR_W    - master address width
//
//   Signals:
//     htrans    master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//     hburst    master burst type
//     haddr     master address
//     hready_m  ready back to the master
//     hresp_m   1 = ERROR response to the master
//     hreq      one-hot (or zero) request toward the slave arbiters
//     hlast     last-beat flag, same bit position as hreq
//     hgrant    per-arbiter grant, already qualified by slave not-wait
//
//   Modports:
//     slave  - the request front-end's view
//     master - the environment's view (master plus arbiters), so it also
//              drives hgrant
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface ahb_master_req_ctrl_if #(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32
) ();
  logic [1:0]           htrans;
  logic [2:0]           hburst;
  logic [ADDR_W-1:0]    haddr;
  logic                 hready_m;
  logic                 hresp_m;
  logic [SLAVE_NUM-1:0] hreq;
  logic [SLAVE_NUM-1:0] hlast;
  logic [SLAVE_NUM-1:0] hgrant;

  modport slave (
    input  htrans, hburst, haddr, hgrant,
    output hready_m, hresp_m, hreq, hlast
  );

  modport master (
    output htrans, hburst, haddr, hgrant,
    input  hready_m, hresp_m, hreq, hlast
  );
endinterface

// File: rtl/ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl
//   Per-master request front-end placed in front of the per-slave AHB
//   arbiters. On NONSEQ it decodes the target slave from
//   haddr[DEC_MSB -: SIDX_W], loads a beat counter from hburst, raises
//   hreq/hlast toward that slave's arbiter and stalls the master until the
//   arbiter grants. Unmapped slave indices get a two-cycle AHB ERROR.
//
//   Parameters:
//     SLAVE_NUM  - number of reachable slave arbiters
//     ADDR_W     - address width
//     DEC_MSB    - MSB of the slave index field in haddr
//     TMO_CYCLES - grant-wait limit (only with REQ_TIMEOUT_EN)
//
//   Ports:
//     hclk      clock
//     hreset_n  asynchronous active-low reset
//     bus       ahb_master_req_ctrl_if.slave (htrans, hburst, haddr, hgrant
//               in; hready_m, hresp_m, hreq, hlast out)
//
//   Optional feature macro: REQ_TIMEOUT_EN
//     When defined, a REQ state that sees no grant for TMO_CYCLES cycles
//     drops the request and answers the master with an ERROR response.
//     When undefined no counter exists and REQ waits indefinitely.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ahb_master_req_ctrl #(
  parameter int SLAVE_NUM  = 4,
  parameter int ADDR_W     = 32,
  parameter int DEC_MSB    = 31,
  parameter int TMO_CYCLES = 256
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  ahb_master_req_ctrl_if.slave bus
);

  localparam int SIDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Beats per transaction; INCR is issued as a series of single beats.
  function automatic logic [4:0] burst_beats(input logic [2:0] hb);
    logic [4:0] n;
    case (hb)
      3'd0, 3'd1: n = 5'd1;   // SINGLE, INCR
      3'd2, 3'd3: n = 5'd4;   // WRAP4, INCR4
      3'd4, 3'd5: n = 5'd8;   // WRAP8, INCR8
      3'd6, 3'd7: n = 5'd16;  // WRAP16, INCR16
      default:    n = 5'd1;
    endcase
    return n;
  endfunction

  // One-hot decode of a slave index; indices >= SLAVE_NUM decode to zero.
  function automatic logic [SLAVE_NUM-1:0] dec_onehot(input logic [SIDX_W-1:0] idx);
    logic [SLAVE_NUM-1:0] v;
    v = {SLAVE_NUM{1'b0}};
    for (int i = 0; i < SLAVE_NUM; i++) begin
      v[i] = (idx == SIDX_W'(i));
    end
    return v;
  endfunction

  state_t               state_r, state_s;
  logic [SIDX_W-1:0]    sidx_r, sidx_s;
  logic [4:0]           beat_cnt_r, beat_cnt_s;
  logic [SLAVE_NUM-1:0] hreq_r, hreq_s;
  logic [SLAVE_NUM-1:0] hlast_r, hlast_s;
  logic [SLAVE_NUM-1:0] sel_s;
  logic [SLAVE_NUM-1:0] term_vec_s;
  logic [SIDX_W-1:0]    addr_sidx_s;
  logic                 addr_ok_s;
  logic                 grant_s;
  logic                 active_s;
  logic                 serving_s;
  logic                 beat_acc_s;
  logic                 early_term_s;
  logic                 tmo_hit_s;
  logic                 hready_s;
  logic                 hresp_s;
  logic [ADDR_W-1:0]    unused_haddr_s;

  // Only the slave index field of haddr is decoded here.
  assign unused_haddr_s = bus.haddr;
  assign addr_sidx_s    = bus.haddr[DEC_MSB -: SIDX_W];
  assign addr_ok_s      = |dec_onehot(addr_sidx_s);
  assign sel_s          = dec_onehot(sidx_r);
  // Grants from arbiters other than the selected one are masked off.
  assign grant_s        = |(bus.hgrant & sel_s);

  // Beat qualification. The arbiter's registered grant arrives while we
  // are still in REQ, so a granted REQ cycle already serves the first beat
  // (first beat at cycle 2 after NONSEQ at cycle 0).
  always_comb begin
    active_s     = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
    serving_s    = (state_r == ST_XFER) || ((state_r == ST_REQ) && grant_s);
    beat_acc_s   = serving_s && grant_s && active_s;
    early_term_s = serving_s && (bus.htrans == HTRANS_IDLE) && (beat_cnt_r > 5'd1);
    term_vec_s   = early_term_s ? sel_s : {SLAVE_NUM{1'b0}};
  end

`ifdef REQ_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Grant-wait counter: counts REQ cycles, clears whenever REQ is left.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_REQ) && (state_s == ST_REQ)) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  // A grant in the limit cycle takes priority over the timeout.
  assign tmo_hit_s = (state_r == ST_REQ) && !grant_s && (tmo_cnt_r == TMO_LAST);
`else
  logic [31:0] unused_tmo_s;

  assign unused_tmo_s = 32'(TMO_CYCLES);
  assign tmo_hit_s    = 1'b0;
`endif

  // Next-state, next slave index and next beat count.
  always_comb begin
    state_s    = state_r;
    sidx_s     = sidx_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.htrans == HTRANS_NONSEQ) begin
          sidx_s     = addr_sidx_s;
          beat_cnt_s = burst_beats(bus.hburst);
          state_s    = addr_ok_s ? ST_REQ : ST_ERR1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ, ST_XFER: begin
        if (early_term_s) begin
          state_s = ST_IDLE;
        end else if (beat_acc_s) begin
          // Saturating decrement; the beat with count 1 closes the burst.
          beat_cnt_s = (beat_cnt_r > 5'd0) ? (beat_cnt_r - 5'd1) : 5'd0;
          state_s    = (beat_cnt_r <= 5'd1) ? ST_IDLE : ST_XFER;
        end else if (serving_s) begin
          state_s = ST_XFER;
        end else if (tmo_hit_s) begin
          state_s = ST_ERR1;
        end else begin
          state_s = state_r;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      ST_ERR2: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request/last vectors for the next cycle, derived from next state/count.
  always_comb begin
    if ((state_s == ST_REQ) || (state_s == ST_XFER)) begin
      hreq_s  = dec_onehot(sidx_s);
      hlast_s = (beat_cnt_s == 5'd1) ? dec_onehot(sidx_s) : {SLAVE_NUM{1'b0}};
    end else begin
      hreq_s  = {SLAVE_NUM{1'b0}};
      hlast_s = {SLAVE_NUM{1'b0}};
    end
  end

  // Master-side response, combinational from state and the selected grant.
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
      end
      ST_REQ, ST_XFER: begin
        // BUSY completes without a beat, so it never needs to stall.
        hready_s = (serving_s && (bus.htrans == HTRANS_BUSY)) ? 1'b1 : grant_s;
        hresp_s  = 1'b0;
      end
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 1'b1;
      end
      ST_ERR2: begin
        hready_s = 1'b1;
        hresp_s  = 1'b1;
      end
      default: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
      end
    endcase
  end

  // Main FSM state and registered request outputs.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r    <= ST_IDLE;
      sidx_r     <= {SIDX_W{1'b0}};
      beat_cnt_r <= 5'd0;
      hreq_r     <= {SLAVE_NUM{1'b0}};
      hlast_r    <= {SLAVE_NUM{1'b0}};
    end else begin
      state_r    <= state_s;
      sidx_r     <= sidx_s;
      beat_cnt_r <= beat_cnt_s;
      hreq_r     <= hreq_s;
      hlast_r    <= hlast_s;
    end
  end

  assign bus.hreq     = hreq_r;
  // Early termination has to flag the last beat in the very cycle the
  // master goes IDLE, so that one case is ORed in combinationally.
  assign bus.hlast    = hlast_r | term_vec_s;
  assign bus.hready_m = hready_s;
  assign bus.hresp_m  = hresp_s;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
`timescale 1ns/1ps
module tb_ahb_master_req_ctrl;

  localparam int SN  = 5;   // non-power-of-two so unmapped indices exist
  localparam int AW  = 32;
  localparam int DM  = 31;
  localparam int TMO = 8;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                         B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  typedef struct packed {
    logic [1:0]    tr;
    logic [2:0]    hb;
    logic [AW-1:0] ad;
    logic [SN-1:0] gr;
  } stim_t;

  typedef struct packed {
    logic [SN-1:0] req;
    logic [SN-1:0] last;
    logic          rdy;
    logic          resp;
  } obs_t;

  logic hclk = 1'b0;
  logic hreset_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  sb_q[$];

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl_if #(.SLAVE_NUM(SN), .ADDR_W(AW)) bus ();

  ahb_master_req_ctrl #(
    .SLAVE_NUM (SN),
    .ADDR_W    (AW),
    .DEC_MSB   (DM),
    .TMO_CYCLES(TMO)
  ) dut (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .bus     (bus)
  );

  function automatic logic [AW-1:0] addr_of(input int s);
    logic [2:0] f;
    f = 3'(s);
    return {f, 29'h0000_0040};
  endfunction

  // Queue one cycle of stimulus and the outputs expected in that cycle.
  task automatic add(input logic [1:0] tr, input logic [2:0] hb, input int s,
                     input logic [SN-1:0] gr, input logic [SN-1:0] rq,
                     input logic [SN-1:0] la, input logic rdy, input logic rsp);
    stim_t st;
    obs_t  ex;
    st = {tr, hb, addr_of(s), gr};
    ex = {rq, la, rdy, rsp};
    stim_q.push_back(st);
    exp_q.push_back(ex);
  endtask

  // Apply the next queued cycle just after the clock edge; its expectation
  // moves to the scoreboard at that moment.
  task automatic drive_next();
    stim_t st;
    obs_t  ex;
    st = stim_q.pop_front();
    ex = exp_q.pop_front();
    @(posedge hclk);
    #1;
    bus.htrans = st.tr;
    bus.hburst = st.hb;
    bus.haddr  = st.ad;
    bus.hgrant = st.gr;
    sb_q.push_back(ex);
  endtask

  task automatic test_reset();
    obs_t ob, ex;
    repeat (2) @(negedge hclk);
    sb_q.push_back({5'b00000, 5'b00000, 1'b1, 1'b0});
    ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
    ex = sb_q.pop_front();
    n_cmp++;
    if (ob !== ex) begin
      n_mis++;
      $display("FAIL reset: got %b want %b (req|last|rdy|resp)", ob, ex);
    end
    // A NONSEQ while reset is held must not start anything.
    bus.htrans = T_NS;
    bus.haddr  = addr_of(1);
    bus.hgrant = 5'b11111;
    @(negedge hclk);
    sb_q.push_back({5'b00000, 5'b00000, 1'b1, 1'b0});
    ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
    ex = sb_q.pop_front();
    n_cmp++;
    if (ob !== ex) begin
      n_mis++;
      $display("FAIL reset_hold: got %b want %b (req|last|rdy|resp)", ob, ex);
    end
    bus.htrans = T_IDLE;
    bus.hgrant = 5'b00000;
    hreset_n   = 1'b1;
  endtask

  task automatic test_single();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,   B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_SINGLE, 1, 5'b00100, 5'b00010, 5'b00010, 1'b0, 1'b0);
    add(T_NS,   B_SINGLE, 1, 5'b00010, 5'b00010, 5'b00010, 1'b1, 1'b0);
    add(T_IDLE, B_SINGLE, 1, 5'b00010, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL single c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_incr4_wait();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,   B_INCR4, 2, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_INCR4, 2, 5'b00000, 5'b00100, 5'b00000, 1'b0, 1'b0);
    add(T_NS,   B_INCR4, 2, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ,  B_INCR4, 2, 5'b00000, 5'b00100, 5'b00000, 1'b0, 1'b0);
    add(T_SEQ,  B_INCR4, 2, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ,  B_INCR4, 2, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ,  B_INCR4, 2, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b0);
    add(T_IDLE, B_INCR4, 2, 5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL incr4_wait c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_unmapped();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,   B_SINGLE, 5, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_IDLE, B_SINGLE, 5, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    add(T_IDLE, B_SINGLE, 5, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1);
    add(T_IDLE, B_SINGLE, 5, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_INCR4,  7, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_IDLE, B_INCR4,  7, 5'b11111, 5'b00000, 5'b00000, 1'b0, 1'b1);
    add(T_IDLE, B_INCR4,  7, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b1);
    add(T_IDLE, B_INCR4,  7, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL unmapped c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_early_term();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,   B_INCR8, 3, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_INCR8, 3, 5'b00000, 5'b01000, 5'b00000, 1'b0, 1'b0);
    add(T_NS,   B_INCR8, 3, 5'b01000, 5'b01000, 5'b00000, 1'b1, 1'b0);
    add(T_BUSY, B_INCR8, 3, 5'b00000, 5'b01000, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ,  B_INCR8, 3, 5'b01000, 5'b01000, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ,  B_INCR8, 3, 5'b01000, 5'b01000, 5'b00000, 1'b1, 1'b0);
    add(T_IDLE, B_INCR8, 3, 5'b01000, 5'b01000, 5'b01000, 1'b1, 1'b0);
    add(T_IDLE, B_INCR8, 3, 5'b01000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_IDLE, B_INCR8, 3, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL early_term c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,   B_SINGLE, 0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_SINGLE, 0, 5'b00000, 5'b00001, 5'b00001, 1'b0, 1'b0);
    add(T_NS,   B_SINGLE, 0, 5'b00001, 5'b00001, 5'b00001, 1'b1, 1'b0);
    add(T_NS,   B_INCR,   4, 5'b00001, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_INCR,   4, 5'b00001, 5'b10000, 5'b10000, 1'b0, 1'b0);
    add(T_NS,   B_INCR,   4, 5'b10000, 5'b10000, 5'b10000, 1'b1, 1'b0);
    add(T_IDLE, B_INCR,   4, 5'b10000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL back_to_back c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_req_wait();
    obs_t ob, ex;
    int   cyc;
`ifdef REQ_TIMEOUT_EN
    // No grant: 8 REQ cycles, then ERR1/ERR2, then IDLE.
    add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00010, 5'b00010, 1'b0, 1'b0);
    end
    add(T_IDLE, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    add(T_IDLE, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1);
    add(T_IDLE, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
`else
    // Without the timeout REQ simply keeps waiting.
    add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00010, 5'b00010, 1'b0, 1'b0);
    end
    add(T_NS,   B_SINGLE, 1, 5'b00010, 5'b00010, 5'b00010, 1'b1, 1'b0);
    add(T_IDLE, B_SINGLE, 1, 5'b00010, 5'b00000, 5'b00000, 1'b1, 1'b0);
`endif
    // Grant arriving in the 8th REQ cycle is honoured either way.
    add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < TMO - 1; i++) begin
      add(T_NS, B_SINGLE, 1, 5'b00000, 5'b00010, 5'b00010, 1'b0, 1'b0);
    end
    add(T_NS,   B_SINGLE, 1, 5'b00010, 5'b00010, 5'b00010, 1'b1, 1'b0);
    add(T_IDLE, B_SINGLE, 1, 5'b00010, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL req_wait c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t ob, ex;
    int   cyc;
    add(T_NS,  B_INCR16, 2, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,  B_INCR16, 2, 5'b00000, 5'b00100, 5'b00000, 1'b0, 1'b0);
    add(T_NS,  B_INCR16, 2, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0);
    add(T_SEQ, B_INCR16, 2, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL rst_mid c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
    // Assert reset between clock edges; outputs must clear immediately.
    @(posedge hclk);
    #1;
    bus.htrans = T_SEQ;
    bus.hgrant = 5'b00100;
    #2;
    hreset_n = 1'b0;
    sb_q.push_back({5'b00000, 5'b00000, 1'b1, 1'b0});
    #1;
    ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
    ex = sb_q.pop_front();
    n_cmp++;
    if (ob !== ex) begin
      n_mis++;
      $display("FAIL rst_mid async: got %b want %b (req|last|rdy|resp)", ob, ex);
    end
    @(negedge hclk);
    bus.htrans = T_IDLE;
    bus.hgrant = 5'b00000;
    hreset_n   = 1'b1;
    // A fresh SINGLE after release.
    add(T_NS,   B_SINGLE, 2, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0);
    add(T_NS,   B_SINGLE, 2, 5'b00000, 5'b00100, 5'b00100, 1'b0, 1'b0);
    add(T_NS,   B_SINGLE, 2, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b0);
    add(T_IDLE, B_SINGLE, 2, 5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      drive_next();
      @(negedge hclk);
      ob = {bus.hreq, bus.hlast, bus.hready_m, bus.hresp_m};
      ex = sb_q.pop_front();
      n_cmp++;
      if (ob !== ex) begin
        n_mis++;
        $display("FAIL rst_after c%0d: got %b want %b (req|last|rdy|resp)", cyc, ob, ex);
      end
      cyc++;
    end
  endtask

  initial begin
    hreset_n   = 1'b0;
    bus.htrans = T_IDLE;
    bus.hburst = B_SINGLE;
    bus.haddr  = {AW{1'b0}};
    bus.hgrant = 5'b00000;
    test_reset();
    test_single();
    test_incr4_wait();
    test_unmapped();
    test_early_term();
    test_back_to_back();
    test_req_wait();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
